// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, widths and divider helper
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } rx_state_t;

  // Half a bit period; start-bit qualification waits this long to land mid-bit.
  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// rtl/uart_rx_os_if.sv - serial line and received-byte signals of the UART receiver
interface uart_rx_os_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 rdy;
  logic                 frame_err;
  logic                 busy;

  modport master (input rx, output data, output rdy, output frame_err, output busy);
  modport slave  (output rx, input data, input rdy, input frame_err, input busy);

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop synchronizer, presets to 1 so an idle-high line reads idle
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= 2'b11;
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling 8N1 UART receiver, mid-bit sampling with CLKS_PER_BIT divider
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_os_if.master  bus
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam int            H         = half_bit(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_BIT   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(H - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [2:0]    LAST_IDX  = 3'(DATA_BITS - 1);

  logic                 rxs;
  logic                 rxs_prev_q;
  rx_state_t            state_q;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 rdy_q;
  logic                 ferr_q;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.rx),
    .q_o   (rxs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      rdy_q      <= 1'b0;
      ferr_q     <= 1'b0;
      rxs_prev_q <= 1'b1;
    end else begin
      rdy_q      <= 1'b0;
      ferr_q     <= 1'b0;
      rxs_prev_q <= rxs;
      case (state_q)
        IDLE: begin
          if (rxs_prev_q && !rxs) begin
            state_q <= START;
            cnt_q   <= CNT_HALF;
          end
        end
        START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (!rxs) begin
            state_q <= DATA;
            idx_q   <= '0;
            cnt_q   <= CNT_BIT;
          end else begin
            state_q <= IDLE;
          end
        end
        DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            shreg_q[idx_q] <= rxs;
            cnt_q          <= CNT_BIT;
            if (idx_q == LAST_IDX) begin
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit gives half a bit of slack for a back-to-back start edge.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (rxs) begin
            data_q  <= shreg_q;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            ferr_q  <= 1'b1;
            state_q <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (rxs) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.rdy       = rdy_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - directed bench for uart_rx_os at 16, 4 and 5 clocks per bit
module tb_uart_rx_os;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_drv [3];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int          rdy_cnt [3];
  int          fe_cnt [3];
  int          both_cnt [3];
  int          rdy_cyc [3];
  int          prev_cyc [3];
  int          fe_cyc [3];
  logic [7:0]  rdy_dat [3];
  logic [7:0]  prev_dat [3];

  uart_rx_os_if if16 ();
  uart_rx_os_if if4 ();
  uart_rx_os_if if5 ();

  assign if16.rx = rx_drv[0];
  assign if4.rx  = rx_drv[1];
  assign if5.rx  = rx_drv[2];

  uart_rx_os #(.CLKS_PER_BIT(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  uart_rx_os #(.CLKS_PER_BIT(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  uart_rx_os #(.CLKS_PER_BIT(5))  dut5  (.clk(clk), .rst_n(rst_n), .bus(if5));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] rdy_v, fe_v;
  logic [7:0] dat_v [3];
  assign rdy_v    = {if5.rdy, if4.rdy, if16.rdy};
  assign fe_v     = {if5.frame_err, if4.frame_err, if16.frame_err};
  assign dat_v[0] = if16.data;
  assign dat_v[1] = if4.data;
  assign dat_v[2] = if5.data;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rdy_v[i]) begin
        rdy_cnt[i]  <= rdy_cnt[i] + 1;
        prev_cyc[i] <= rdy_cyc[i];
        rdy_cyc[i]  <= cyc;
        prev_dat[i] <= rdy_dat[i];
        rdy_dat[i]  <= dat_v[i];
      end
      if (fe_v[i]) begin
        fe_cnt[i] <= fe_cnt[i] + 1;
        fe_cyc[i] <= cyc;
      end
      if (rdy_v[i] && fe_v[i]) both_cnt[i] <= both_cnt[i] + 1;
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drive_bit(input int idx, input logic v, input int n);
    rx_drv[idx] = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int idx, input int cpb, input logic [7:0] b,
                            input logic stop_v, output int c0);
    c0 = cyc;
    drive_bit(idx, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_bit(idx, b[i], cpb);
    drive_bit(idx, stop_v, cpb);
    rx_drv[idx] = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (if16.data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", if16.data); end
    n_cmp++; if (if16.rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy got %b want 0", if16.rdy); end
    n_cmp++; if (if16.frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr got %b want 0", if16.frame_err); end
    n_cmp++; if (if16.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", if16.busy); end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_single();
    int c0;
    int r0, f0;
    r0 = rdy_cnt[0]; f0 = fe_cnt[0];
    align();
    send_frame(0, 16, 8'hA5, 1'b1, c0);
    wait_cyc(c0 + 200);
    n_cmp++; if (rdy_cnt[0] - r0 !== 1) begin n_bad++; $display("FAIL single_rdy_count got %0d want 1", rdy_cnt[0] - r0); end
    n_cmp++; if (rdy_cyc[0] !== c0 + 155) begin n_bad++; $display("FAIL single_rdy_cycle got %0d want %0d", rdy_cyc[0], c0 + 155); end
    n_cmp++; if (if16.data !== 8'hA5) begin n_bad++; $display("FAIL single_data got %h want a5", if16.data); end
    n_cmp++; if (fe_cnt[0] - f0 !== 0) begin n_bad++; $display("FAIL single_ferr got %0d want 0", fe_cnt[0] - f0); end
  endtask

  task automatic test_glitch();
    int c0;
    int r0, f0;
    r0 = rdy_cnt[0]; f0 = fe_cnt[0];
    align();
    c0 = cyc;
    drive_bit(0, 1'b0, 3);
    rx_drv[0] = 1'b1;
    wait_cyc(c0 + 4);
    n_cmp++; if (if16.busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_high got %b want 1", if16.busy); end
    wait_cyc(c0 + 12);
    n_cmp++; if (if16.busy !== 1'b0) begin n_bad++; $display("FAIL glitch_back_idle got %b want 0", if16.busy); end
    wait_cyc(c0 + 60);
    n_cmp++; if ((rdy_cnt[0] - r0) + (fe_cnt[0] - f0) !== 0) begin n_bad++; $display("FAIL glitch_no_output got %0d pulses want 0", (rdy_cnt[0] - r0) + (fe_cnt[0] - f0)); end
    n_cmp++; if (if16.data !== 8'hA5) begin n_bad++; $display("FAIL glitch_data got %h want a5", if16.data); end
  endtask

  task automatic test_frame_err();
    int c0;
    int r0, f0;
    r0 = rdy_cnt[0]; f0 = fe_cnt[0];
    align();
    send_frame(0, 16, 8'h3C, 1'b0, c0);
    rx_drv[0] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rx_drv[0] = 1'b1;
    n_cmp++; if (if16.busy !== 1'b1) begin n_bad++; $display("FAIL ferr_wait_hi_busy got %b want 1", if16.busy); end
    n_cmp++; if (fe_cnt[0] - f0 !== 1) begin n_bad++; $display("FAIL ferr_count got %0d want 1", fe_cnt[0] - f0); end
    n_cmp++; if (fe_cyc[0] !== c0 + 155) begin n_bad++; $display("FAIL ferr_cycle got %0d want %0d", fe_cyc[0], c0 + 155); end
    n_cmp++; if (if16.data !== 8'hA5) begin n_bad++; $display("FAIL ferr_data_kept got %h want a5", if16.data); end
    wait_cyc(c0 + 206);
    n_cmp++; if (if16.busy !== 1'b0) begin n_bad++; $display("FAIL ferr_release_idle got %b want 0", if16.busy); end
    wait_cyc(c0 + 400);
    n_cmp++; if (rdy_cnt[0] - r0 !== 0) begin n_bad++; $display("FAIL ferr_no_rdy got %0d want 0", rdy_cnt[0] - r0); end
  endtask

  task automatic test_back_to_back();
    int c0, c1;
    int r0;
    r0 = rdy_cnt[0];
    align();
    send_frame(0, 16, 8'h00, 1'b1, c0);
    send_frame(0, 16, 8'hFF, 1'b1, c1);
    wait_cyc(c1 + 200);
    n_cmp++; if (rdy_cnt[0] - r0 !== 2) begin n_bad++; $display("FAIL b2b_count got %0d want 2", rdy_cnt[0] - r0); end
    n_cmp++; if (prev_dat[0] !== 8'h00) begin n_bad++; $display("FAIL b2b_first_data got %h want 00", prev_dat[0]); end
    n_cmp++; if (rdy_dat[0] !== 8'hFF) begin n_bad++; $display("FAIL b2b_second_data got %h want ff", rdy_dat[0]); end
    n_cmp++; if (prev_cyc[0] !== c0 + 155) begin n_bad++; $display("FAIL b2b_first_cycle got %0d want %0d", prev_cyc[0], c0 + 155); end
    n_cmp++; if (rdy_cyc[0] - prev_cyc[0] !== 160) begin n_bad++; $display("FAIL b2b_spacing got %0d want 160", rdy_cyc[0] - prev_cyc[0]); end
  endtask

  task automatic test_reset_mid();
    int c0;
    int r0;
    r0 = rdy_cnt[0];
    align();
    drive_bit(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 16);
    drive_bit(0, 1'b0, 6);
    n_cmp++; if (if16.busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before got %b want 1", if16.busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (if16.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", if16.busy); end
    n_cmp++; if (if16.data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data got %h want 00", if16.data); end
    rx_drv[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    align();
    send_frame(0, 16, 8'h5A, 1'b1, c0);
    wait_cyc(c0 + 200);
    n_cmp++; if (rdy_cnt[0] - r0 !== 1) begin n_bad++; $display("FAIL rstmid_rdy_count got %0d want 1", rdy_cnt[0] - r0); end
    n_cmp++; if (if16.data !== 8'h5A) begin n_bad++; $display("FAIL rstmid_data_after got %h want 5a", if16.data); end
  endtask

  task automatic test_divider();
    int c4, c5;
    int r4, r5;
    r4 = rdy_cnt[1]; r5 = rdy_cnt[2];
    align();
    send_frame(1, 4, 8'h81, 1'b1, c4);
    align();
    send_frame(2, 5, 8'h81, 1'b1, c5);
    wait_cyc(c5 + 80);
    n_cmp++; if (rdy_cnt[1] - r4 !== 1) begin n_bad++; $display("FAIL div4_count got %0d want 1", rdy_cnt[1] - r4); end
    n_cmp++; if (if4.data !== 8'h81) begin n_bad++; $display("FAIL div4_data got %h want 81", if4.data); end
    n_cmp++; if (rdy_cyc[1] !== c4 + 41) begin n_bad++; $display("FAIL div4_cycle got %0d want %0d", rdy_cyc[1], c4 + 41); end
    n_cmp++; if (rdy_cnt[2] - r5 !== 1) begin n_bad++; $display("FAIL div5_count got %0d want 1", rdy_cnt[2] - r5); end
    n_cmp++; if (if5.data !== 8'h81) begin n_bad++; $display("FAIL div5_data got %h want 81", if5.data); end
    n_cmp++; if (rdy_cyc[2] !== c5 + 50) begin n_bad++; $display("FAIL div5_cycle got %0d want %0d", rdy_cyc[2], c5 + 50); end
    n_cmp++; if (both_cnt[0] + both_cnt[1] + both_cnt[2] !== 0) begin n_bad++; $display("FAIL rdy_ferr_overlap got %0d want 0", both_cnt[0] + both_cnt[1] + both_cnt[2]); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) rx_drv[i] = 1'b1;
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_divider();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
